// File: rtl/mod12_counter.sv
// Modulo-12 up-counter with parallel load and terminal-count decode.
// An out-of-range load value or state always falls back to zero.
module mod12_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] c,
   output logic             tc
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_inc;
   logic [WIDTH-1:0] w_next;
   logic             w_in_ok;
   logic             w_wrap;

   // <= LAST rather than < MODULUS so MODULUS == 2**WIDTH cannot overflow
   assign w_in_ok = (in <= LAST);
   assign w_wrap  = (r_cnt >= LAST);
   assign w_inc   = r_cnt + WIDTH'(1);

   always_comb begin
      w_next = ZERO;
      if (rst) begin
         w_next = ZERO;
      end else if (load) begin
         w_next = w_in_ok ? in : ZERO;
      end else if (w_wrap) begin
         w_next = ZERO;
      end else begin
         w_next = w_inc;
      end
   end

   always_ff @(posedge clk) begin
      r_cnt <= w_next;
   end

   assign c  = r_cnt;
   assign tc = (r_cnt == LAST);

endmodule

// File: tb/tb_mod12_counter.sv
// Directed-vector bench for mod12_counter with a per-cycle reference model.
// Literal expectations after each edge pin the model's behaviour.
module tb_mod12_counter;

   logic       clk;
   logic       rst;
   logic       load;
   logic [3:0] in;
   logic [3:0] c;
   logic       tc;

   int tests;
   int fails;
   int m_cnt;
   bit m_valid;

   mod12_counter #(.WIDTH(4), .MODULUS(12)) dut (
      .clk (clk),
      .rst (rst),
      .load(load),
      .in  (in),
      .c   (c),
      .tc  (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: count value as a plain integer in 0..11
   always @(posedge clk) begin
      if (rst) begin
         m_cnt   = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (load) m_cnt = (int'(in) < 12) ? int'(in) : 0;
         else      m_cnt = (m_cnt + 1) % 12;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         tests++;
         if (int'(c) != m_cnt || tc != (m_cnt == 11)) begin
            fails++;
            $display("FAIL model_cmp t=%0t c=%0d tc=%0b required c=%0d tc=%0b",
                     $time, c, tc, m_cnt, (m_cnt == 11));
         end
      end
   end

   task automatic check(input string name, input int exp_c, input bit exp_tc);
      tests++;
      if (int'(c) != exp_c || tc !== exp_tc) begin
         fails++;
         $display("FAIL %s c=%0d tc=%0b required c=%0d tc=%0b",
                  name, c, tc, exp_c, exp_tc);
      end
   endtask

   task automatic step(input bit r, input bit l, input int v);
      rst  = r;
      load = l;
      in   = 4'(v);
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      m_cnt   = 0;
      m_valid = 1'b0;
      rst     = 1'b0;
      load    = 1'b0;
      in      = 4'd0;
      @(negedge clk);

      step(1, 0, 0);
      check("reset", 0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0);
         check("count_seq", (i + 1) % 12, (i == 10));
      end

      step(0, 1, 5);
      check("load5", 5, 1'b0);
      step(0, 0, 0); check("after_load6", 6, 1'b0);
      step(0, 0, 0); check("after_load7", 7, 1'b0);
      step(0, 0, 0); check("after_load8", 8, 1'b0);

      step(0, 1, 11);
      check("load11_tc", 11, 1'b1);
      step(0, 0, 0);
      check("wrap", 0, 1'b0);

      step(0, 0, 0);
      step(0, 1, 13);
      check("load13_illegal", 0, 1'b0);
      step(0, 1, 9);
      check("load9", 9, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 9);
         check("load9_hold", 9, 1'b0);
      end
      step(0, 0, 0);
      check("resume_after_hold", 10, 1'b0);

      step(0, 1, 7);
      step(0, 0, 0);
      check("count_to8", 8, 1'b0);
      step(1, 1, 6);
      check("rst_over_load", 0, 1'b0);
      step(0, 1, 6);
      check("load6_after_rst", 6, 1'b0);

      rst  = 1'b0;
      load = 1'b0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_between_edges", 7, 1'b0);

      step(0, 1, 15);
      check("load15_illegal", 0, 1'b0);
      step(0, 1, 4);
      step(0, 0, 0);
      step(1, 0, 0);
      check("rst_midcount", 0, 1'b0);
      step(0, 1, 12);
      check("load12_illegal", 0, 1'b0);
      step(0, 0, 0);
      check("count_after_illegal", 1, 1'b0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
